// File: rtl/clock_time_keeper_if.sv
// clock_time_keeper_if: set-mode flags, adjust commands and time fields between controller and keeper.
// The oPM signal exists only when CLOCK_12H_EN is defined.
interface clock_time_keeper_if;
  logic       iSet_Hour;
  logic       iSet_Min;
  logic       iHour_Up;
  logic       iHour_Down;
  logic       iMin_Up;
  logic       iMin_Down;
  logic [4:0] oHour;
  logic [5:0] oMin;
  logic [5:0] oSec;
  logic       oTick_1s;
  logic       oBlink;
`ifdef CLOCK_12H_EN
  logic       oPM;
  modport master (output iSet_Hour, iSet_Min, iHour_Up, iHour_Down, iMin_Up, iMin_Down,
                  input oHour, oMin, oSec, oTick_1s, oBlink, oPM);
  modport slave  (input iSet_Hour, iSet_Min, iHour_Up, iHour_Down, iMin_Up, iMin_Down,
                  output oHour, oMin, oSec, oTick_1s, oBlink, oPM);
`else
  modport master (output iSet_Hour, iSet_Min, iHour_Up, iHour_Down, iMin_Up, iMin_Down,
                  input oHour, oMin, oSec, oTick_1s, oBlink);
  modport slave  (input iSet_Hour, iSet_Min, iHour_Up, iHour_Down, iMin_Up, iMin_Down,
                  output oHour, oMin, oSec, oTick_1s, oBlink);
`endif
endinterface

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 1 Hz prescaler plus hh:mm:ss counters with set-mode adjust commands.
// Optional CLOCK_12H_EN macro presents a 12-hour oHour with an oPM flag.
module clock_time_keeper #(
  parameter int P_CLK_HZ = 100000000
) (
  input logic                iClk,
  input logic                iRst_n,
  clock_time_keeper_if.slave bus
);
  localparam int LP_W = $clog2(P_CLK_HZ);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(P_CLK_HZ - 1);
  localparam logic [LP_W-1:0] LP_HALF = LP_W'(P_CLK_HZ / 2);
  logic [LP_W-1:0] r_prs, w_prs_nx;
  logic [4:0]      r_hour, w_hour_nx;
  logic [5:0]      r_min, r_sec, w_min_nx, w_sec_nx;
  logic            r_tick;
  logic [3:0]      r_cmd_q, w_cmd, w_step;
  logic            w_set, w_wrap, w_hu, w_hd, w_mu, w_md, w_min_c, w_hour_c;
  assign w_cmd  = {bus.iHour_Up, bus.iHour_Down, bus.iMin_Up, bus.iMin_Down};
  assign w_step = w_cmd & ~r_cmd_q;
  always_comb begin
    w_set     = bus.iSet_Hour | bus.iSet_Min;
    w_wrap    = !w_set && r_prs == LP_MAX;
    // Simultaneous up and down edges on one field cancel out
    w_hu      = bus.iSet_Hour & w_step[3] & ~w_step[2];
    w_hd      = bus.iSet_Hour & w_step[2] & ~w_step[3];
    w_mu      = bus.iSet_Min & w_step[1] & ~w_step[0];
    w_md      = bus.iSet_Min & w_step[0] & ~w_step[1];
    w_min_c   = w_wrap && r_sec == 6'd59;
    w_hour_c  = w_min_c && r_min == 6'd59;
    w_prs_nx  = (w_set || w_wrap) ? '0 : r_prs + 1'b1;
    w_sec_nx  = w_set ? '0 : w_wrap ? (r_sec == 6'd59 ? 6'd0 : r_sec + 1'b1) : r_sec;
    w_min_nx  = (w_mu || w_min_c) ? (r_min == 6'd59 ? 6'd0 : r_min + 1'b1) :
                w_md ? (r_min == 6'd0 ? 6'd59 : r_min - 1'b1) : r_min;
    w_hour_nx = (w_hu || w_hour_c) ? (r_hour == 5'd23 ? 5'd0 : r_hour + 1'b1) :
                w_hd ? (r_hour == 5'd0 ? 5'd23 : r_hour - 1'b1) : r_hour;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_prs   <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_tick  <= 1'b0;
      r_cmd_q <= '0;
    end else begin
      r_prs   <= w_prs_nx;
      r_sec   <= w_sec_nx;
      r_min   <= w_min_nx;
      r_hour  <= w_hour_nx;
      r_tick  <= w_wrap;
      r_cmd_q <= w_cmd;
    end
  end
  assign bus.oMin     = r_min;
  assign bus.oSec     = r_sec;
  assign bus.oTick_1s = r_tick;
  assign bus.oBlink   = r_prs < LP_HALF;
`ifdef CLOCK_12H_EN
  assign bus.oHour = (r_hour == 5'd0 || r_hour == 5'd12) ? 5'd12 :
                     r_hour > 5'd12 ? r_hour - 5'd12 : r_hour;
  assign bus.oPM   = r_hour >= 5'd12;
`else
  assign bus.oHour = r_hour;
`endif
endmodule

// File: tb/tb_clock_time_keeper.sv
// tb_clock_time_keeper: directed vectors and multi-cycle sequences for clock_time_keeper at P_CLK_HZ=10.
module tb_clock_time_keeper;
  typedef struct packed {
    logic       sh, sm, hu, hd, mu, md;
    logic [4:0] h;
    logic [5:0] m;
  } vec_t;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vt[17];
  clock_time_keeper_if bus();
  clock_time_keeper #(.P_CLK_HZ(10)) dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus.slave));
  always #5 iClk = ~iClk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask
  task automatic mode(input logic sh, input logic sm);
    bus.iSet_Hour = sh;
    bus.iSet_Min  = sm;
  endtask
  task automatic cmd(input logic hu, input logic hd, input logic mu, input logic md);
    bus.iHour_Up = hu; bus.iHour_Down = hd; bus.iMin_Up = mu; bus.iMin_Down = md;
  endtask
  task automatic pulse(input logic hu, input logic hd, input logic mu, input logic md);
    cmd(hu, hd, mu, md);
    cyc(1);
    cmd(0, 0, 0, 0);
    cyc(1);
  endtask
  function automatic vec_t mk(input logic sh, sm, hu, hd, mu, md, input int h, m);
    mk = '{sh, sm, hu, hd, mu, md, 5'(h), 6'(m)};
  endfunction
  initial begin
    int ticks, last, gap_err, hit, bad;
    vt[0]  = mk(0,0,1,0,0,0, 0,0);
    vt[1]  = mk(1,0,0,0,0,0, 0,0);
    vt[2]  = mk(1,0,0,1,0,0, 23,0);
    vt[3]  = mk(1,0,0,1,0,0, 23,0);
    vt[4]  = mk(1,0,0,0,0,0, 23,0);
    vt[5]  = mk(1,0,1,1,0,0, 23,0);
    vt[6]  = mk(1,0,0,0,0,0, 23,0);
    vt[7]  = mk(1,0,1,0,0,0, 0,0);
    vt[8]  = mk(1,0,0,0,1,0, 0,0);
    vt[9]  = mk(0,1,0,0,0,0, 0,0);
    vt[10] = mk(0,1,0,0,0,1, 0,59);
    vt[11] = mk(0,1,0,0,1,0, 0,0);
    vt[12] = mk(0,1,0,0,1,0, 0,0);
    vt[13] = mk(0,1,0,0,0,0, 0,0);
    vt[14] = mk(0,1,0,0,1,0, 0,1);
    vt[15] = mk(1,1,1,0,0,1, 1,0);
    vt[16] = mk(0,0,0,0,0,0, 1,0);
    mode(0, 0);
    cmd(0, 0, 0, 0);
    #12;
    chk("reset_time", {bus.oHour, bus.oMin, bus.oSec}, 0);
    chk("reset_tick", bus.oTick_1s, 0);
    chk("reset_blink", bus.oBlink, 1);
`ifdef CLOCK_12H_EN
    chk("reset_pm", bus.oPM, 0);
`endif
    cyc(1);
    iRst_n = 1'b1;
    ticks = 0; last = -1; gap_err = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (bus.oTick_1s) begin
        if ((last < 0 && i != 9) || (last >= 0 && i - last != 10)) gap_err++;
        last = i;
        ticks++;
      end
    end
    chk("tick_count", ticks, 60);
    chk("tick_spacing_errs", gap_err, 0);
    chk("run600_hms", {bus.oHour, bus.oMin, bus.oSec}, {5'd0, 6'd1, 6'd0});
    mode(1, 1);
    cyc(1);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    chk("preload_hm", {bus.oHour, bus.oMin, bus.oSec}, {5'd23, 6'd59, 6'd0});
    mode(0, 0);
    cyc(590);
    chk("pre_roll_hms", {bus.oHour, bus.oMin, bus.oSec}, {5'd23, 6'd59, 6'd59});
    cyc(9);
    chk("edge_before_roll", {bus.oHour, bus.oMin, bus.oSec}, {5'd23, 6'd59, 6'd59});
    cyc(1);
    chk("rollover_hms", {bus.oHour, bus.oMin, bus.oSec}, 0);
    chk("rollover_tick", bus.oTick_1s, 1);
    foreach (vt[k]) begin
      mode(vt[k].sh, vt[k].sm);
      cmd(vt[k].hu, vt[k].hd, vt[k].mu, vt[k].md);
      cyc(1);
      chk($sformatf("vec%0d_hms", k), {bus.oHour, bus.oMin, bus.oSec}, {vt[k].h, vt[k].m, 6'd0});
    end
    mode(0, 1);
    cmd(0, 0, 1, 0);
    cyc(50);
    cmd(0, 0, 0, 0);
    cyc(1);
    chk("held_up_one_step", {bus.oHour, bus.oMin}, {5'd1, 6'd1});
    pulse(0, 0, 0, 1);
    chk("min_down", {bus.oHour, bus.oMin}, {5'd1, 6'd0});
    pulse(0, 0, 0, 1);
    chk("min_down_wrap_no_borrow", {bus.oHour, bus.oMin}, {5'd1, 6'd59});
    mode(0, 0);
    cyc(7);
    mode(1, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.oSec != 0 || bus.oTick_1s) bad++;
    end
    chk("set_hold_sec_tick", bad, 0);
    chk("set_hold_blink", bus.oBlink, 1);
    mode(0, 0);
    hit = -1;
    for (int i = 0; i < 30 && hit < 0; i++) begin
      cyc(1);
      if (i == 3) chk("blink_first_half", bus.oBlink, 1);
      if (i == 4) chk("blink_second_half", bus.oBlink, 0);
      if (bus.oTick_1s) hit = i;
    end
    chk("tick_after_release", hit, 9);
    chk("sec_after_release", bus.oSec, 1);
    @(posedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    chk("async_reset_time", {bus.oHour, bus.oMin, bus.oSec}, 0);
    chk("async_reset_tick_blink", {bus.oTick_1s, bus.oBlink}, {1'b0, 1'b1});
    cyc(1);
    iRst_n = 1'b1;
`ifdef CLOCK_12H_EN
    cyc(1);
    chk("h12_midnight", {bus.oHour, bus.oPM}, {5'd12, 1'b0});
    mode(1, 0);
    repeat (13) pulse(1, 0, 0, 0);
    chk("h12_13", {bus.oHour, bus.oPM}, {5'd1, 1'b1});
    pulse(0, 1, 0, 0);
    chk("h12_noon", {bus.oHour, bus.oPM}, {5'd12, 1'b1});
    mode(0, 0);
`endif
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
